accel_scheduler: RTL and testbench

Command scheduler between `gp_cpu` and the three crypto engines (hash H, encrypt E, decrypt D). It accepts engine commands from the CPU through a valid/ready port and buffers them in an in-order queue. Each command is dispatched to its target engine as a one-cycle start pulse carrying a memory index. The block tracks per-engine busy state from the engines' done pulses and raises sticky per-engine interrupts back to the CPU.

---
 rtl/accel_scheduler.sv | 144 ++++++++++++++
 tb/tb_accel_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_scheduler.sv
// accel_scheduler
//   In-order command scheduler between the CPU and the hash (H), encrypt (E)
//   and decrypt (D) engines. CPU commands are buffered in a small circular
//   queue; the head command is launched to its engine with a one-cycle start
//   pulse once that engine is idle. Engine done pulses clear busy and raise
//   sticky interrupts that the CPU clears with write-1-to-clear.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        CPU command handshake
//   cmd_op, cmd_index          00 hash, 01 encrypt, 10 decrypt, 11 reserved
//   h_start/e_start/d_start    one-cycle engine start pulses
//   eng_index                  index of the command being started
//   h_done/e_done/d_done       engine completion pulses
//   h_int/e_int/d_int          sticky completion interrupts
//   int_clr                    {d,e,h} write-1-to-clear for the interrupts
//   busy                       {d,e,h} engine has a command in flight
//   err                        sticky: reserved op was received
//   idle                       queue empty and no engine busy
module accel_scheduler #(
    parameter int IDX_W  = 16,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_index,
    output logic             cmd_ready,
    output logic             h_start,
    output logic             e_start,
    output logic             d_start,
    output logic [IDX_W-1:0] eng_index,
    input  logic             h_done,
    input  logic             e_done,
    input  logic             d_done,
    output logic             h_int,
    output logic             e_int,
    output logic             d_int,
    input  logic [2:0]       int_clr,
    output logic [2:0]       busy,
    output logic             err,
    output logic             idle
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(QDEPTH);

    logic [1:0]       opQ  [QDEPTH];
    logic [IDX_W-1:0] idxQ [QDEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      count;

    // Holds cmd_ready low while in reset and until the first clock after release.
    logic             readyEn;

    logic [2:0]       startR;
    logic [2:0]       intR;

    logic [2:0]       headMask;
    logic [2:0]       doneHit;
    logic             accept;
    logic             doPush;
    logic             doPop;

    assign cmd_ready = readyEn && (count != FULL_COUNT);
    assign idle      = (count == '0) && (busy == 3'b000);

    assign h_start = startR[0];
    assign e_start = startR[1];
    assign d_start = startR[2];
    assign h_int   = intR[0];
    assign e_int   = intR[1];
    assign d_int   = intR[2];

    // Reserved ops never reach the queue, so the head is always 00/01/10.
    always_comb begin
        headMask = 3'b000;
        case (opQ[rdPtr])
            2'b00:   headMask = 3'b001;
            2'b01:   headMask = 3'b010;
            2'b10:   headMask = 3'b100;
            default: headMask = 3'b000;
        endcase
    end

    // Done pulses for engines that have nothing in flight are dropped.
    assign doneHit = {d_done, e_done, h_done} & busy;
    assign accept  = cmd_valid && cmd_ready;
    assign doPush  = accept && (cmd_op != 2'b11);
    assign doPop   = (count != '0) && ((busy & headMask) == 3'b000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                opQ[i]  <= '0;
                idxQ[i] <= '0;
            end
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            readyEn   <= 1'b0;
            startR    <= 3'b000;
            intR      <= 3'b000;
            busy      <= 3'b000;
            err       <= 1'b0;
            eng_index <= '0;
        end else begin
            readyEn <= 1'b1;
            startR  <= 3'b000;

            if (doPush) begin
                opQ[wrPtr]  <= cmd_op;
                idxQ[wrPtr] <= cmd_index;
                wrPtr       <= wrPtr + 1'b1;
            end

            if (accept && (cmd_op == 2'b11)) begin
                err <= 1'b1;
            end

            if (doPop) begin
                rdPtr     <= rdPtr + 1'b1;
                eng_index <= idxQ[rdPtr];
                startR    <= headMask;
            end

            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Dispatch only targets an idle engine and done only clears a
            // busy one, so the two terms never touch the same bit.
            busy <= (busy & ~doneHit) | (doPop ? headMask : 3'b000);

            // A done landing together with its clear leaves the interrupt set.
            intR <= (intR & ~int_clr) | doneHit;
        end
    end

endmodule

// File: tb/tb_accel_scheduler.sv
module tb_accel_scheduler;

    localparam int IDX_W  = 16;
    localparam int QDEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_index;
    logic             cmd_ready;
    logic             h_start, e_start, d_start;
    logic [IDX_W-1:0] eng_index;
    logic             h_done, e_done, d_done;
    logic             h_int, e_int, d_int;
    logic [2:0]       int_clr;
    logic [2:0]       busy;
    logic             err;
    logic             idle;

    accel_scheduler #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_index(cmd_index),
        .cmd_ready(cmd_ready),
        .h_start(h_start), .e_start(e_start), .d_start(d_start),
        .eng_index(eng_index),
        .h_done(h_done), .e_done(e_done), .d_done(d_done),
        .h_int(h_int), .e_int(e_int), .d_int(d_int),
        .int_clr(int_clr), .busy(busy), .err(err), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]       op;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    cmd_t             mq[$];
    logic [2:0]       mBusy;
    logic [2:0]       mStart;
    logic [2:0]       mInt;
    logic             mErr;
    logic [IDX_W-1:0] mEngIdx;
    bit               mOut;

    always @(posedge clk) begin
        logic [2:0] doneV;
        logic [2:0] launched;
        bit         canTake;
        cmd_t       c;
        if (!rst_n) begin
            mq.delete();
            mBusy = 0; mStart = 0; mInt = 0; mErr = 0; mEngIdx = 0; mOut = 0;
        end else begin
            canTake  = mOut && (mq.size() < QDEPTH);
            doneV    = {d_done, e_done, h_done} & mBusy;
            launched = 0;
            if (mq.size() > 0 && !mBusy[mq[0].op]) begin
                c = mq.pop_front();
                launched[c.op] = 1'b1;
                mEngIdx = c.idx;
            end
            if (cmd_valid && canTake) begin
                if (cmd_op == 2'b11) mErr = 1'b1;
                else begin
                    c.op = cmd_op; c.idx = cmd_index;
                    mq.push_back(c);
                end
            end
            mBusy  = (mBusy & ~doneV) | launched;
            mInt   = (mInt & ~int_clr) | doneV;
            mStart = launched;
            mOut   = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk("m_cmd_ready", cmd_ready, mOut && (mq.size() < QDEPTH));
            chk("m_start", {d_start, e_start, h_start}, mStart);
            chk("m_eng_index", eng_index, mEngIdx);
            chk("m_busy", busy, mBusy);
            chk("m_int", {d_int, e_int, h_int}, mInt);
            chk("m_err", err, mErr);
            chk("m_idle", idle, (mq.size() == 0) && (mBusy == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCmd(input logic [1:0] op, input logic [IDX_W-1:0] idx, output bit ok);
        ok = 0;
        cmd_valid = 1; cmd_op = op; cmd_index = idx;
        for (int n = 0; n < 50; n++) begin
            ok = cmd_ready;
            step();
            if (ok) break;
        end
        cmd_valid = 0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 200; n++) begin
            if (idle) begin done = 1; break; end
            {d_done, e_done, h_done} = busy;
            step();
            {d_done, e_done, h_done} = 3'b000;
        end
        chk("drain_idle", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_index = 0;
        h_done = 0; e_done = 0; d_done = 0; int_clr = 0;
        step();
        checkEn = 1;
        step(); step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        step();
        chk("ready_after_release", cmd_ready, 1);

        // single hash command
        pushCmd(2'b00, 16'h0040, ok);
        chk("t1_no_start_yet", h_start, 0);
        step();
        chk("t1_h_start", h_start, 1);
        chk("t1_eng_index", eng_index, 16'h0040);
        chk("t1_busy", busy, 3'b001);
        step();
        chk("t1_start_width", h_start, 0);
        h_done = 1; step(); h_done = 0;
        chk("t1_busy_clr", busy, 3'b000);
        chk("t1_h_int", h_int, 1);
        chk("t1_idle", idle, 1);
        int_clr = 3'b001; step(); int_clr = 0;
        chk("t1_h_int_clr", h_int, 0);

        // fill the queue behind a busy hash engine
        pushCmd(2'b00, 16'h0100, ok);
        step();
        chk("t2_h_busy", busy, 3'b001);
        pushCmd(2'b00, 16'h0101, ok);
        pushCmd(2'b01, 16'h0102, ok);
        pushCmd(2'b10, 16'h0103, ok);
        pushCmd(2'b00, 16'h0104, ok);
        cmd_valid = 1; cmd_op = 2'b01; cmd_index = 16'h0105;
        chk("t2_full_ready", cmd_ready, 0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t2_blocked_starts", {d_start, e_start, h_start}, 3'b000);
        end
        h_done = 1; step(); h_done = 0;
        chk("t2_still_full", cmd_ready, 0);
        step();
        chk("t2_h_start", h_start, 1);
        chk("t2_h_idx", eng_index, 16'h0101);
        chk("t2_ready_again", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("t2_e_start", e_start, 1);
        chk("t2_e_idx", eng_index, 16'h0102);
        step();
        chk("t2_d_start", d_start, 1);
        chk("t2_d_idx", eng_index, 16'h0103);
        step();
        chk("t2_hol_block", {d_start, e_start, h_start}, 3'b000);
        chk("t2_all_busy", busy, 3'b111);
        drain();
        int_clr = 3'b111; step(); int_clr = 0;

        // pointer wrap with alternating E/D
        for (int i = 0; i < 10; i++) begin
            logic [1:0] op;
            op = (i % 2 == 1) ? 2'b10 : 2'b01;
            pushCmd(op, 16'h0200 + 16'(i), ok);
            step();
            chk("t3_start", {d_start, e_start, h_start}, (op == 2'b01) ? 3'b010 : 3'b100);
            chk("t3_idx", eng_index, 16'h0200 + 16'(i));
            if (op == 2'b01) e_done = 1; else d_done = 1;
            step();
            e_done = 0; d_done = 0;
        end
        chk("t3_idle", idle, 1);
        int_clr = 3'b111; step(); int_clr = 0;

        // reserved op
        pushCmd(2'b11, 16'h0300, ok);
        chk("t4_accepted", ok, 1);
        chk("t4_err", err, 1);
        chk("t4_idle", idle, 1);
        step();
        chk("t4_no_start", {d_start, e_start, h_start}, 3'b000);

        // corner events
        e_done = 1; step(); e_done = 0;
        chk("t5_stray_e_done", e_int, 0);
        pushCmd(2'b10, 16'h0400, ok);
        step();
        chk("t5_d_busy", busy, 3'b100);
        d_done = 1; int_clr = 3'b100; step(); d_done = 0; int_clr = 0;
        chk("t5_set_wins", d_int, 1);
        int_clr = 3'b100; step(); int_clr = 0;
        chk("t5_d_int_clr", d_int, 0);
        chk("t5_err_sticky", err, 1);

        // reset with queued and in-flight work
        pushCmd(2'b01, 16'h0500, ok);
        step();
        pushCmd(2'b01, 16'h0501, ok);
        pushCmd(2'b01, 16'h0502, ok);
        pushCmd(2'b10, 16'h0503, ok);
        chk("t6_e_busy", busy, 3'b010);
        chk("t6_not_idle", idle, 0);
        rst_n = 0; step();
        chk("t6_rst_ready", cmd_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_idx", eng_index, 0);
        chk("t6_rst_idle", idle, 1);
        rst_n = 1; step();
        e_done = 1; step(); e_done = 0;
        chk("t6_e_int_ignored", e_int, 0);
        step();
        chk("t6_no_start", {d_start, e_start, h_start}, 3'b000);
        chk("t6_idle", idle, 1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
